wdata_chan_mngr: RTL and testbench

Write-data channel manager: the transmitting end of the bus write-data channel. Accepts one 128-bit line plus 16-bit byte mask from the local side, then drives it onto the bus as a burst of 1–4 32-bit beats with `wstrb` and `wlast`. Sits between the manager-side write queue and the bus, opposite the write-data channel subordinate. Reports burst completion to the write-address/response logic.

---
 rtl/wdata_chan_mngr_pkg.sv | 27 ++
 rtl/wdata_chan_mngr_if.sv | 28 ++
 rtl/wdata_chan_mngr.sv | 93 +++++++++
 tb/tb_wdata_chan_mngr.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wdata_chan_mngr_pkg.sv
// Shared constants for the write-data channel: FSM encodings and beat/line geometry.
// Both the manager and the subordinate side of the channel import this package.
package wdata_chan_mngr_pkg;

  localparam int BEAT_W    = 32;
  localparam int LINE_W    = 128;
  localparam int MAX_BEATS = 4;
  localparam int STRB_W    = BEAT_W / 8;
  localparam int MASK_W    = LINE_W / 8;
  localparam int CNT_W     = $clog2(MAX_BEATS);

  // DEFO is sticky; every unused encoding decodes into it.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_DEFO = 2'b11;

  function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] line,
                                                input logic [CNT_W-1:0]  idx);
    return line[BEAT_W*idx +: BEAT_W];
  endfunction

  function automatic logic [STRB_W-1:0] strb_of(input logic [MASK_W-1:0] mask,
                                                input logic [CNT_W-1:0]  idx);
    return mask[STRB_W*idx +: STRB_W];
  endfunction

endpackage

// File: rtl/wdata_chan_mngr_if.sv
// Local-side line request and bus write-data channel signals of the manager.
// master = the channel manager itself; slave = the local queue plus bus peer.
interface wdata_chan_mngr_if;
  import wdata_chan_mngr_pkg::*;

  logic                  wdat_m_req;
  logic [LINE_W-1:0]     wdat_m_data;
  logic [MASK_W-1:0]     wdat_m_mask;
  logic [CNT_W-1:0]      wdat_m_len;
  logic                  wdat_m_ack;
  logic                  wvalid;
  logic                  wready;
  logic [BEAT_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  finish_mwd;

  modport master (
    input  wdat_m_req, wdat_m_data, wdat_m_mask, wdat_m_len, wready,
    output wdat_m_ack, wvalid, wdata, wstrb, wlast, finish_mwd
  );

  modport slave (
    output wdat_m_req, wdat_m_data, wdat_m_mask, wdat_m_len, wready,
    input  wdat_m_ack, wvalid, wdata, wstrb, wlast, finish_mwd
  );

endinterface

// File: rtl/wdata_chan_mngr.sv
// Write-data channel manager: captures one 128-bit line and emits it as a
// 1..4 beat burst of 32-bit beats, with zero-bubble chaining of lines.
module wdata_chan_mngr
  import wdata_chan_mngr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  wdata_chan_mngr_if.master  bus,
  output logic [1:0]         dbg_state
);

  // Handshakes: a bus beat transfers on a rising edge where wvalid & wready;
  // wvalid and the beat payload stay stable until then. A line transfers on
  // an edge where wdat_m_req & wdat_m_ack; the local side holds req and
  // payload until ack, and ack is only raised when the line can be taken.

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              fin_q, fin_d;

  logic              valid;
  logic              last;
  logic              ack;

  always_comb begin
    valid = (state_q == ST_SEND);
    last  = valid && (cnt_q == len_q);
    ack   = rst_n && bus.wdat_m_req &&
            ((state_q == ST_IDLE) || (valid && bus.wready && last));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;
    len_d   = len_q;
    fin_d   = valid && bus.wready && last;

    case (state_q)
      ST_IDLE: begin
        if (ack) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.wready) begin
          if (!last)    cnt_d   = cnt_q + 2'd1;
          else if (!ack) state_d = ST_IDLE;
        end
      end
      ST_DEFO: state_d = ST_DEFO;
      default: state_d = ST_DEFO;
    endcase

    // A capture always restarts the beat counter, whether from IDLE or chained.
    if (ack) begin
      data_d = bus.wdat_m_data;
      mask_d = bus.wdat_m_mask;
      len_d  = bus.wdat_m_len;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      fin_q   <= fin_d;
    end
  end

  // Payload is gated with wvalid so the bus sees zeros outside a burst.
  assign bus.wdat_m_ack = ack;
  assign bus.wvalid     = valid;
  assign bus.wlast      = last;
  assign bus.wdata      = valid ? beat_of(data_q, cnt_q) : '0;
  assign bus.wstrb      = valid ? strb_of(mask_q, cnt_q) : '0;
  assign bus.finish_mwd = fin_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_wdata_chan_mngr.sv
// Directed bench for wdata_chan_mngr: a beat-queue model checked every cycle,
// plus hand-computed literal checks taken from the intended burst behaviour.
module tb_wdata_chan_mngr;
  import wdata_chan_mngr_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wdata_chan_mngr_if bus_if();

  wdata_chan_mngr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // ---------------- model: queue of beats still owed to the bus ----------------
  // Entry = {last, strb[3:0], data[31:0]}.
  logic [36:0] exp_q[$];
  logic        fin_exp = 1'b0;

  function automatic logic model_ack();
    if (!rst_n || !bus_if.wdat_m_req) return 1'b0;
    if (exp_q.size() == 0) return 1'b1;
    return (exp_q.size() == 1) && bus_if.wready;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fin_exp <= 1'b0;
    end else begin
      logic take;
      take = model_ack();
      fin_exp <= (exp_q.size() == 1) && bus_if.wready;
      if (exp_q.size() != 0 && bus_if.wready) void'(exp_q.pop_front());
      if (take) begin
        for (int k = 0; k <= int'(bus_if.wdat_m_len); k++)
          exp_q.push_back({k == int'(bus_if.wdat_m_len),
                           bus_if.wdat_m_mask[4*k +: 4],
                           bus_if.wdat_m_data[32*k +: 32]});
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic [36:0] head;
      logic [63:0] act, expv;
      head = (exp_q.size() != 0) ? exp_q[0] : 37'd0;
      expv = {24'd0, model_ack(), exp_q.size() != 0, head[36], head[35:32], head[31:0], fin_exp};
      act  = {24'd0, bus_if.wdat_m_ack, bus_if.wvalid, bus_if.wlast, bus_if.wstrb,
              bus_if.wdata, bus_if.finish_mwd};
      chk("model", act, expv);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [127:0] d, input logic [15:0] m, input logic [1:0] l);
    bus_if.wdat_m_req  = 1'b1;
    bus_if.wdat_m_data = d;
    bus_if.wdat_m_mask = m;
    bus_if.wdat_m_len  = l;
  endtask

  // Bus beat as {valid, last, strb, data}.
  function automatic logic [63:0] beat_now();
    return {26'd0, bus_if.wvalid, bus_if.wlast, bus_if.wstrb, bus_if.wdata};
  endfunction

  function automatic logic [63:0] beat(input logic v, input logic l,
                                       input logic [3:0] s, input logic [31:0] d);
    return {26'd0, v, l, s, d};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seen[$];
    int          vcnt;
    int          busy;

    rst_n = 1'b0;
    bus_if.wdat_m_req  = 1'b1;
    bus_if.wdat_m_data = '1;
    bus_if.wdat_m_mask = '1;
    bus_if.wdat_m_len  = 2'd3;
    bus_if.wready      = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_outputs", beat_now(), beat(0, 0, 4'h0, 32'h0));
    chk("rst_ack_fin", {bus_if.wdat_m_ack, bus_if.finish_mwd}, 2'b00);
    step();
    rst_n = 1'b1;
    bus_if.wdat_m_req = 1'b0;
    step();

    // Single beat.
    offer({96'd0, 32'hA5A5_0001}, 16'h000F, 2'd0);
    @(negedge clk); chk("t1_ack", bus_if.wdat_m_ack, 1);
    step(); bus_if.wdat_m_req = 1'b0;
    @(negedge clk); chk("t1_beat", beat_now(), beat(1, 1, 4'hF, 32'hA5A5_0001));
    step();
    @(negedge clk); chk("t1_fin", {bus_if.finish_mwd, bus_if.wvalid}, 2'b10);
    step();

    // Four beats, one strobe bit per beat.
    offer({32'h4, 32'h3, 32'h2, 32'h1}, 16'h8421, 2'd3);
    @(negedge clk); chk("t2_ack", bus_if.wdat_m_ack, 1);
    step(); bus_if.wdat_m_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2_beat%0d", i), beat_now(),
          beat(1, i == 3, 4'(1 << i), 32'(i + 1)));
      step();
    end
    @(negedge clk); chk("t2_fin", {bus_if.finish_mwd, bus_if.wvalid}, 2'b10);
    step();

    // Backpressure on the second beat for three cycles.
    offer({32'h13, 32'h12, 32'h11, 32'h10}, 16'hFFFF, 2'd3);
    @(negedge clk); chk("t3_ack", bus_if.wdat_m_ack, 1);
    step(); bus_if.wdat_m_req = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 9; c++) begin
      bus_if.wready = !(c >= 1 && c <= 3);
      @(negedge clk);
      if (bus_if.wvalid) vcnt++;
      if (bus_if.wvalid && bus_if.wready) seen.push_back(bus_if.wdata);
      if (!bus_if.wready) chk("t3_hold", beat_now(), beat(1, 0, 4'hF, 32'h11));
      step();
    end
    bus_if.wready = 1'b1;
    chk("t3_valid_cycles", vcnt, 7);
    chk("t3_beat_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_order%0d", i), (i < seen.size()) ? seen[i] : 32'hDEAD, 32'h10 + i);

    // Back-to-back: second line waits for the first line's last handshake.
    offer({64'd0, 32'hA1, 32'hA0}, 16'h00FF, 2'd1);
    @(negedge clk); chk("t4_ack1", bus_if.wdat_m_ack, 1);
    step();
    offer({64'd0, 32'hB1, 32'hB0}, 16'h00FF, 2'd1);
    @(negedge clk); chk("t4_no_early_ack", bus_if.wdat_m_ack, 0);
    step();
    @(negedge clk);
    chk("t4_ack2", bus_if.wdat_m_ack, 1);
    chk("t4_lastA", beat_now(), beat(1, 1, 4'hF, 32'hA1));
    step(); bus_if.wdat_m_req = 1'b0;
    @(negedge clk);
    chk("t4_B0", beat_now(), beat(1, 0, 4'hF, 32'hB0));
    chk("t4_fin_overlap", bus_if.finish_mwd, 1);
    step();
    @(negedge clk); chk("t4_B1", beat_now(), beat(1, 1, 4'hF, 32'hB1));
    step();
    @(negedge clk); chk("t4_fin", {bus_if.finish_mwd, bus_if.wvalid}, 2'b10);
    step();

    // Reset during the first beat of a four-beat burst.
    offer({32'h24, 32'h23, 32'h22, 32'h21}, 16'hFFFF, 2'd3);
    step(); bus_if.wdat_m_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_abandon", {bus_if.wvalid, bus_if.wlast, bus_if.finish_mwd}, 3'b000);
    offer({96'd0, 32'hC0}, 16'h000F, 2'd0);
    @(negedge clk); chk("t5_ack", bus_if.wdat_m_ack, 1);
    step(); bus_if.wdat_m_req = 1'b0;
    @(negedge clk); chk("t5_beat", beat_now(), beat(1, 1, 4'hF, 32'hC0));
    step();
    @(negedge clk); chk("t5_fin", bus_if.finish_mwd, 1);
    step();

    // No request for 20 cycles with wready toggling.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      bus_if.wready = c[0];
      @(negedge clk);
      if (bus_if.wvalid || bus_if.wdat_m_ack) busy++;
      step();
    end
    chk("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
